uart_rx_16x: RTL and testbench

UART_RX_16X -- requirements
Module: uart_rx_16x

---
 rtl/uart_rx_16x.sv | 126 ++++++++++++
 tb/tb_uart_rx_16x.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_16x.sv
// UART receiver with 16x oversampling: 8N1 frames, single mid-bit sample,
// valid/acknowledge handshake and frame-error / overrun pulses.
`timescale 1ns/1ps
module uart_rx_16x #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_out,
    output logic       rx_done,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state, state_nxt;
    logic             rx_sync_p0, rx_sync_p1, rx_prev;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       sub_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             tick, fall, mid_start, mid_bit;
    logic             data_sample, stop_ok, stop_bad;

    // Stage p0/p1: two-flop synchronizer, idles high; rx_prev feeds the edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev    <= rx_sync_p1;
        end
    end

    assign fall      = rx_prev & ~rx_sync_p1;
    assign tick      = (state != IDLE) && (div_cnt == DIV_LAST);
    assign mid_start = tick && (sub_cnt == 4'd7);
    assign mid_bit   = tick && (sub_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fall) state_nxt = START;
            START:     if (mid_start) state_nxt = rx_sync_p1 ? IDLE : DATA;
            DATA:      if (mid_bit && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:      if (mid_bit) state_nxt = rx_sync_p1 ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_sync_p1) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_sample = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            DATA:    data_sample = mid_bit;
            STOP: begin
                stop_ok  = mid_bit &  rx_sync_p1;
                stop_bad = mid_bit & ~rx_sync_p1;
            end
            default: ;
        endcase
    end

    // Sub-bit counter restarts after the start mid-point so later samples land mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sub_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            sub_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (mid_start && state == START) sub_cnt <= '0;
            else if (tick)                   sub_cnt <= sub_cnt + 4'd1;
            if (data_sample) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (data_sample) shift <= {rx_sync_p1, shift[7:1]};
    end

    // Stage p2: registered results, one cycle after the stop-bit sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_out    <= 8'h00;
            rx_done   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_done   <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= stop_ok & rx_valid & ~rx_ack;
            if (stop_ok) begin
                rx_out   <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x using a scaled clock/baud ratio (DIV=4)
// so that every scenario fits in a short run.
`timescale 1ns/1ps
module tb_uart_rx_16x;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 25_000;
    localparam int DIV       = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT       = DIV * 16;
    localparam int LAT_NOM   = 9 * BIT + BIT / 2;
    // posedges after the start-edge drive until the stop-bit sampling cycle begins
    localparam int ACK_EDGES = 152 * DIV + 2;

    logic       clk = 1'b0, rst = 1'b0, rx_in = 1'b1, rx_ack = 1'b0;
    logic [7:0] rx_out;
    logic       rx_done, rx_valid, frame_err, overrun;

    uart_rx_16x #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_ack(rx_ack),
        .rx_out(rx_out), .rx_done(rx_done), .rx_valid(rx_valid),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int         checks = 0, fails = 0;
    int         cyc = 0, start_cyc = 0, last_done_cyc = 0;
    int         done_cnt = 0, err_cnt = 0, ovr_cnt = 0;
    int         obs_rd = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         d0, f0, o0, lat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && rx_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            obs_q.push_back(rx_out);
        end
        if (rst && frame_err) err_cnt++;
        if (rst && overrun)   ovr_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_in = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_in = stop;
        repeat (BIT) @(negedge clk);
        if (stop) rx_in = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rx_out !== 8'h00) begin fails++; $display("FAIL reset_rx_out: got %h, required 00", rx_out); end
        checks++; if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_rx_done: got %b, required 0", rx_done); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        d0 = done_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0); end
        lat = last_done_cyc - start_cyc;
        checks++; if (lat < LAT_NOM - 2 * DIV || lat > LAT_NOM + 2 * DIV) begin fails++; $display("FAIL basic_latency: got %0d cycles, required %0d +/- %0d", lat, LAT_NOM, 2 * DIV); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL basic_rx_valid: got %b, required 1", rx_valid); end
        checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin fails++; $display("FAIL basic_sb_count: got %0d, required %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL basic_byte: got %h, required %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
        obs_rd = obs_q.size(); exp_q.delete();
        rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0; @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_ack_clear: got %b, required 0", rx_valid); end
        rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0; @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || rx_out !== 8'h55) begin fails++; $display("FAIL basic_ack_idle: got valid=%b out=%h, required valid=0 out=55", rx_valid, rx_out); end
    endtask

    task automatic test_glitch;
        d0 = done_cnt; f0 = err_cnt;
        @(negedge clk); rx_in = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checks++; if (done_cnt != d0 || err_cnt != f0) begin fails++; $display("FAIL glitch_no_output: got done=%0d err=%0d, required 0 and 0", done_cnt - d0, err_cnt - f0); end
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin fails++; $display("FAIL glitch_sb_count: got %0d, required %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL glitch_byte: got %h, required %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
        obs_rd = obs_q.size(); exp_q.delete();
    endtask

    task automatic test_frame_err;
        d0 = done_cnt; f0 = err_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (err_cnt - f0 != 1) begin fails++; $display("FAIL ferr_pulse_count: got %0d, required 1", err_cnt - f0); end
        checks++; if (done_cnt != d0) begin fails++; $display("FAIL ferr_no_done: got %0d, required 0", done_cnt - d0); end
        checks++; if (rx_out !== 8'hA3 || rx_valid !== 1'b1) begin fails++; $display("FAIL ferr_hold: got out=%h valid=%b, required out=a3 valid=1", rx_out, rx_valid); end
        rx_in = 1'b1;
        repeat (BIT) @(negedge clk);
        checks++; if (done_cnt != d0 || err_cnt - f0 != 1) begin fails++; $display("FAIL ferr_after_high: got done=%0d err=%0d, required 0 and 1", done_cnt - d0, err_cnt - f0); end
        rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0; @(negedge clk);
    endtask

    task automatic test_overrun;
        d0 = done_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (ovr_cnt - o0 != 1) begin fails++; $display("FAIL ovr_pulse_count: got %0d, required 1", ovr_cnt - o0); end
        checks++; if (done_cnt - d0 != 2) begin fails++; $display("FAIL ovr_done_count: got %0d, required 2", done_cnt - d0); end
        checks++; if (rx_out !== 8'h22 || rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_state: got out=%h valid=%b, required out=22 valid=1", rx_out, rx_valid); end
        checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin fails++; $display("FAIL ovr_sb_count: got %0d, required %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL ovr_byte: got %h, required %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
        obs_rd = obs_q.size(); exp_q.delete();
        rx_ack = 1'b1; @(negedge clk); rx_ack = 1'b0; @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_ack_clear: got %b, required 0", rx_valid); end
    endtask

    task automatic test_ack_coincident;
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        o0 = ovr_cnt;
        exp_q.push_back(8'h7E);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                @(negedge clk);
                repeat (ACK_EDGES) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
                @(negedge clk);
                checks++; if (rx_done !== 1'b1 || rx_valid !== 1'b1 || overrun !== 1'b0) begin fails++; $display("FAIL ackco_edge: got done=%b valid=%b ovr=%b, required 1 1 0", rx_done, rx_valid, overrun); end
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (ovr_cnt != o0) begin fails++; $display("FAIL ackco_no_overrun: got %0d pulses, required 0", ovr_cnt - o0); end
        checks++; if (rx_valid !== 1'b1 || rx_out !== 8'h7E) begin fails++; $display("FAIL ackco_state: got valid=%b out=%h, required valid=1 out=7e", rx_valid, rx_out); end
        checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin fails++; $display("FAIL ackco_sb_count: got %0d, required %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL ackco_byte: got %h, required %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
        obs_rd = obs_q.size(); exp_q.delete();
    endtask

    task automatic test_reset_midframe;
        logic [7:0] partial;
        partial = 8'hAA;
        @(negedge clk); rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = partial[i];
            repeat (BIT) @(negedge clk);
        end
        #2 rst = 1'b0;
        rx_in = 1'b1;
        #1;
        checks++; if (rx_out !== 8'h00 || rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_async: got out=%h valid=%b, required out=00 valid=0", rx_out, rx_valid); end
        repeat (3) @(negedge clk);
        checks++; if (rx_done !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL rstmid_pulses: got done=%b err=%b ovr=%b, required 0 0 0", rx_done, frame_err, overrun); end
        rst = 1'b1;
        d0 = done_cnt; f0 = err_cnt;
        repeat (2 * BIT) @(negedge clk);
        checks++; if (done_cnt != d0 || err_cnt != f0) begin fails++; $display("FAIL rstmid_quiet: got done=%0d err=%0d, required 0 0", done_cnt - d0, err_cnt - f0); end
        exp_q.push_back(8'hF0);
        send_byte(8'hF0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx_out !== 8'hF0 || rx_valid !== 1'b1) begin fails++; $display("FAIL rstmid_next: got out=%h valid=%b, required out=f0 valid=1", rx_out, rx_valid); end
        checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin fails++; $display("FAIL rstmid_sb_count: got %0d, required %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL rstmid_byte: got %h, required %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
        obs_rd = obs_q.size(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_ack_coincident();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
